// File: rtl/ipf_pkg.sv
// Shared constants, command encodings and state type for the image-patch filter.
package ipf_pkg;

  localparam logic [2:0] CMD_FINISH = 3'd0;
  localparam logic [2:0] CMD_START  = 3'd1;
  localparam logic [2:0] CMD_NEXT   = 3'd2;

  localparam int TILE      = 8;         // tile is TILE x TILE pixels
  localparam int TAPS      = 9;         // 3x3 kernel taps
  localparam int KPG       = 4;         // kernels per group
  localparam int LANES     = 128;       // KPG * BEAT_ROWS * TILE
  localparam int WWORDS    = 9;         // 64-bit weight words (72 bytes)
  localparam int BEAT_ROWS = TILE / 2;  // output rows carried by one beat

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ipf_engine_dot9.sv
// One result lane: 3x3 dot product of pixels and weights, shifted right, then
// saturated (IPF_SAT_EN defined) or truncated (default) to Out_Width bits.
// Purely combinational.
module ipf_dot9
  import ipf_pkg::*;
#(
  parameter int In_Width  = 8,
  parameter int Out_Width = 9,
  parameter int Shift     = 8
) (
  input  logic [TAPS*In_Width-1:0] i_px,
  input  logic [TAPS*In_Width-1:0] i_wt,
  output logic [Out_Width-1:0]     o_res
);

  localparam int PROD_W = 2 * In_Width;
  localparam int SUM_W  = PROD_W + 4;  // nine products need four extra bits

  logic [PROD_W-1:0] w_prod [TAPS];
  logic [SUM_W-1:0]  w_pair [4];
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_shr;

  // Reduce a shifted sum to the lane width.
  function automatic logic [Out_Width-1:0] fit_lane(input logic [SUM_W-1:0] v);
`ifdef IPF_SAT_EN
    return (|v[SUM_W-1:Out_Width]) ? {Out_Width{1'b1}} : v[Out_Width-1:0];
`else
    return v[Out_Width-1:0];
`endif
  endfunction

  // Nine unsigned products, balanced adder tree, then the fixed right shift.
  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      w_prod[t] = i_px[t*In_Width +: In_Width] * i_wt[t*In_Width +: In_Width];
    end
    for (int p = 0; p < 4; p++) begin
      w_pair[p] = SUM_W'(w_prod[2*p]) + SUM_W'(w_prod[2*p+1]);
    end
    w_sum = (w_pair[0] + w_pair[1]) + (w_pair[2] + w_pair[3]) + SUM_W'(w_prod[TAPS-1]);
    w_shr = w_sum >> Shift;
  end

  assign o_res = fit_lane(w_shr);

endmodule

// File: rtl/ipf_engine.sv
// Image-patch filter top: 8x8 tile buffer, 72-byte weight buffer, change-detected
// command FSM and a two-beat result sequencer over 128 ipf_dot9 lanes.
// Lane saturation is enabled by defining IPF_SAT_EN; otherwise lanes truncate.
module ipf_engine
  import ipf_pkg::*;
#(
  parameter int In_Width   = 8,
  parameter int Out_Width  = 9,
  parameter int Addr_Width = 16,
  parameter int Shift      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 ctrl,
  input  logic                       i_valid,
  input  logic [TILE*In_Width-1:0]   i_data,
  input  logic                       w_valid,
  input  logic [TILE*In_Width-1:0]   w_data,
  output logic                       res_valid,
  output logic [LANES*Out_Width-1:0] res,
  output logic                       finish
);

  logic [TILE*In_Width-1:0]   r_tile [TILE];
  logic [TILE*In_Width-1:0]   r_wt   [WWORDS];
  logic [2:0]                 r_rptr;
  logic [3:0]                 r_wptr;
  state_e                     r_state, w_state_nxt;
  logic [1:0]                 r_phase, w_phase_nxt;
  logic                       r_grp, w_grp_nxt;
  logic                       w_finish_nxt;
  logic [2:0]                 r_ctrl_prev;
  logic [Addr_Width-1:0]      r_beat_cnt;
  logic                       w_cmd_new;
  logic                       w_emit;
  logic                       w_half;
  logic                       w_wr_en;
  logic                       w_beat_unused;
  logic [LANES*Out_Width-1:0] w_res;
  logic [In_Width-1:0]        w_pad   [TILE+2][TILE+2];
  logic [In_Width-1:0]        w_wbyte [WWORDS*TILE];

  // A command acts only on the cycle ctrl differs from its previous sample;
  // X/Z compares unknown and so never fires.
  assign w_cmd_new = (ctrl != r_ctrl_prev);
  // Buffers are frozen for the whole pass so the lanes see stable operands.
  assign w_wr_en   = (r_state != BUSY);
  // Phase 1 emits rows 0..3, phase 2 emits rows 4..7.
  assign w_half    = (r_phase == 2'd2);
  // The beat counter has no consumer outside this block.
  assign w_beat_unused = ^r_beat_cnt;

  // Command decode and pass sequencing.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_grp_nxt    = r_grp;
    w_finish_nxt = finish;
    w_emit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_new) begin
          case (ctrl)
            CMD_START: begin
              w_state_nxt = BUSY;
              w_phase_nxt = 2'd0;
            end
            CMD_NEXT:   w_grp_nxt = ~r_grp;
            CMD_FINISH: begin
              w_state_nxt  = DONE;
              w_finish_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        w_phase_nxt = r_phase + 2'd1;
        w_emit      = (r_phase != 2'd0);
        if (r_phase == 2'd2) begin
          w_state_nxt = IDLE;
          w_phase_nxt = 2'd0;
        end
      end
      DONE: ;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state, pointers and the registered result beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_phase     <= 2'd0;
      r_grp       <= 1'b0;
      r_ctrl_prev <= 3'b111;
      r_rptr      <= 3'd0;
      r_wptr      <= 4'd0;
      r_beat_cnt  <= '0;
      res_valid   <= 1'b0;
      res         <= '0;
      finish      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_grp       <= w_grp_nxt;
      r_ctrl_prev <= ctrl;
      finish      <= w_finish_nxt;
      if (w_wr_en && i_valid) r_rptr <= r_rptr + 3'd1;
      if (w_wr_en && w_valid) r_wptr <= (r_wptr == 4'(WWORDS-1)) ? 4'd0 : r_wptr + 4'd1;
      res_valid <= w_emit;
      if (w_emit) begin
        res        <= w_res;
        r_beat_cnt <= r_beat_cnt + Addr_Width'(1);
      end
    end
  end

  // Tile row and weight word storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && i_valid) r_tile[r_rptr] <= i_data;
    if (w_wr_en && w_valid) r_wt[r_wptr]   <= w_data;
  end

  // Tile surrounded by a one-pixel zero border for same-size padding.
  always_comb begin
    for (int r = 0; r < TILE + 2; r++) begin
      for (int c = 0; c < TILE + 2; c++) w_pad[r][c] = '0;
    end
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) w_pad[r+1][c+1] = r_tile[r][c*In_Width +: In_Width];
    end
  end

  // Weight words viewed as a flat byte array; kernel K occupies bytes 9K..9K+8.
  always_comb begin
    for (int b = 0; b < WWORDS * TILE; b++) begin
      w_wbyte[b] = r_wt[b / TILE][(b % TILE)*In_Width +: In_Width];
    end
  end

  for (genvar gk = 0; gk < KPG; gk++) begin : g_k
    for (genvar gr = 0; gr < BEAT_ROWS; gr++) begin : g_r
      for (genvar gc = 0; gc < TILE; gc++) begin : g_c
        localparam int L = gk*BEAT_ROWS*TILE + gr*TILE + gc;
        logic [TAPS*In_Width-1:0] w_px;
        logic [TAPS*In_Width-1:0] w_wt;
        for (genvar gt = 0; gt < TAPS; gt++) begin : g_t
          assign w_px[gt*In_Width +: In_Width] = w_half ? w_pad[gr + gt/3 + BEAT_ROWS][gc + gt%3]
                                                        : w_pad[gr + gt/3][gc + gt%3];
          assign w_wt[gt*In_Width +: In_Width] = r_grp ? w_wbyte[TAPS*(gk + KPG) + gt]
                                                       : w_wbyte[TAPS*gk + gt];
        end
        ipf_dot9 #(
          .In_Width (In_Width),
          .Out_Width(Out_Width),
          .Shift    (Shift)
        ) u_dot (
          .i_px (w_px),
          .i_wt (w_wt),
          .o_res(w_res[L*Out_Width +: Out_Width])
        );
      end
    end
  end

endmodule

// File: tb/tb_ipf_engine.sv
// Directed bench for ipf_engine: uniform-tile passes, group switching,
// overflow handling, command change-detect, finish and mid-pass reset.
`timescale 1ns/1ps
module tb_ipf_engine;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    ctrl = 3'b111;
  logic          i_valid = 1'b0;
  logic [63:0]   i_data = '0;
  logic          w_valid = 1'b0;
  logic [63:0]   w_data = '0;
  logic          res_valid;
  logic [1151:0] res;
  logic          finish;

  ipf_engine dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .res_valid(res_valid),
    .res      (res),
    .finish   (finish)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int            pulse_cyc[$];
  logic [1151:0] pulse_dat[$];
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      pulse_cyc.push_back(edge_cnt);
      pulse_dat.push_back(res);
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctrl = 3'b111; i_valid = 1'b0; w_valid = 1'b0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic wr_row(input logic [7:0] v);
    i_valid = 1'b1; i_data = {8{v}};
    tick(1);
    i_valid = 1'b0;
  endtask

  task automatic wr_word(input logic [63:0] v);
    w_valid = 1'b1; w_data = v;
    tick(1);
    w_valid = 1'b0;
  endtask

  // Eight rows and nine words, the first eight cycles writing both together.
  task automatic load_all(input logic [7:0] p, input logic [7:0] w);
    for (int i = 0; i < 9; i++) begin
      i_valid = (i < 8); i_data = {8{p}};
      w_valid = 1'b1;    w_data = {8{w}};
      tick(1);
    end
    i_valid = 1'b0; w_valid = 1'b0;
  endtask

  // Called just after an edge; ctrl=1 is sampled at the next edge, edge N.
  task automatic start_pass(output int n);
    ctrl = 3'd1;
    n = edge_cnt + 1;
    tick(1);
  endtask

  task automatic check_pass(input string tag, input int n, input int base,
                            output logic [1151:0] b0, output logic [1151:0] b1);
    b0 = '0; b1 = '0;
    chk({tag, "_npulse"}, 64'(pulse_cyc.size() - base), 2);
    if (pulse_cyc.size() >= base + 2) begin
      chk({tag, "_cyc0"}, 64'(pulse_cyc[base]),     64'(n + 2));
      chk({tag, "_cyc1"}, 64'(pulse_cyc[base + 1]), 64'(n + 3));
      b0 = pulse_dat[base];
      b1 = pulse_dat[base + 1];
    end
  endtask

  function automatic logic [8:0] lane(input logic [1151:0] b, input int l);
    return b[l*9 +: 9];
  endfunction

  // Uniform tile and weights of 0x10: each lane equals the count of in-tile taps.
  function automatic int flat_errs(input logic [1151:0] b, input int half);
    int e, rr, c, r, nr, nc;
    e = 0;
    for (int l = 0; l < 128; l++) begin
      rr = (l / 8) % 4;
      c  = l % 8;
      r  = half * 4 + rr;
      nr = (r == 0 || r == 7) ? 2 : 3;
      nc = (c == 0 || c == 7) ? 2 : 3;
      if (b[l*9 +: 9] != 9'(nr * nc)) e++;
    end
    return e;
  endfunction

  initial begin
    logic [1151:0] b0, b1;
    int n, base;

    // Reset state
    rst = 1'b0;
    tick(2);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_zero", |res, 0);
    chk("rst_finish", finish, 0);
    rst = 1'b1;
    tick(1);

    // T1: uniform 0x10 tile and weights, group 0
    load_all(8'h10, 8'h10);
    base = pulse_cyc.size();
    start_pass(n);
    tick(6);
    check_pass("t1", n, base, b0, b1);
    chk("t1_corner", lane(b0, 0), 4);
    chk("t1_edge", lane(b0, 1), 6);
    chk("t1_inner", lane(b0, 9), 9);
    chk("t1_b1_corner", lane(b1, 127), 4);
    chk("t1_b0_all", 64'(flat_errs(b0, 0)), 0);
    chk("t1_b1_all", 64'(flat_errs(b1, 1)), 0);

    // T2: NEXT then START gives group 1, identical with uniform weights
    ctrl = 3'd2;
    tick(2);
    base = pulse_cyc.size();
    start_pass(n);
    tick(6);
    check_pass("t2", n, base, b0, b1);
    chk("t2_b0_all", 64'(flat_errs(b0, 0)), 0);
    chk("t2_b1_all", 64'(flat_errs(b1, 1)), 0);

    // T2z: words 5..8 zero; group 1 kernel 4 keeps only taps 0..3
    for (int w = 0; w < 9; w++) wr_word(w < 5 ? {8{8'h10}} : 64'd0);
    ctrl = 3'd3;
    tick(2);
    base = pulse_cyc.size();
    start_pass(n);
    tick(6);
    check_pass("t2z", n, base, b0, b1);
    chk("t2z_k0_inner", lane(b0, 9), 4);
    chk("t2z_k0_corner", lane(b0, 0), 0);
    chk("t2z_k0_top", lane(b0, 3), 1);
    chk("t2z_k1_inner", lane(b0, 41), 0);
    chk("t2z_k0_b1_bottom", lane(b1, 27), 4);

    // T3: full-scale operands overflow the lane width
    load_all(8'hFF, 8'hFF);
    ctrl = 3'd3;
    tick(2);
    base = pulse_cyc.size();
    start_pass(n);
    tick(6);
    check_pass("t3", n, base, b0, b1);
`ifdef IPF_SAT_EN
    chk("t3_inner", lane(b0, 9), 511);
    chk("t3_corner", lane(b0, 0), 511);
    chk("t3_edge", lane(b0, 1), 511);
`else
    chk("t3_inner", lane(b0, 9), 238);
    chk("t3_corner", lane(b0, 0), 504);
    chk("t3_edge", lane(b0, 1), 500);
`endif

    // T4: a fresh START while busy is ignored; held ctrl gives one pass
    ctrl = 3'd3;
    tick(2);
    base = pulse_cyc.size();
    start_pass(n);
    ctrl = 3'd3;
    tick(1);
    ctrl = 3'd1;
    tick(30);
    check_pass("t4", n, base, b0, b1);

    // T5: FINISH is sticky and silences the engine
    chk("t5_pre_finish", finish, 0);
    ctrl = 3'd0;
    tick(1);
    chk("t5_finish", finish, 1);
    base = pulse_cyc.size();
    for (int i = 0; i < 10; i++) begin
      ctrl = 3'(i % 3); i_valid = 1'b1; w_valid = 1'b1;
      tick(1);
    end
    i_valid = 1'b0; w_valid = 1'b0;
    tick(5);
    chk("t5_no_beats", 64'(pulse_cyc.size() - base), 0);
    chk("t5_finish_sticky", finish, 1);

    // T6: reset during beat 0 aborts the pass and clears pointers/group
    do_reset();
    chk("t6_finish_clr", finish, 0);
    load_all(8'h10, 8'h10);
    wr_row(8'h00);
    wr_row(8'h00);
    wr_word({8{8'h10}});
    base = pulse_cyc.size();
    start_pass(n);
    tick(2);
    chk("t6_beat0_up", res_valid, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_finish", finish, 0);
    chk("t6_rst_res_zero", |res, 0);
    tick(2);
    ctrl = 3'b111;
    rst = 1'b1;
    tick(8);
    chk("t6_no_beat1", 64'(pulse_cyc.size() - base), 0);

    // Post-reset writes must land in row 0/1 and word 0, group back to 0
    wr_row(8'h10);
    wr_row(8'h10);
    wr_word(64'd0);
    base = pulse_cyc.size();
    start_pass(n);
    tick(6);
    check_pass("t6p", n, base, b0, b1);
    chk("t6_k0_r0c0", lane(b0, 0), 1);
    chk("t6_k0_r1c1", lane(b0, 9), 1);
    chk("t6_k1_r0c1", lane(b0, 33), 6);
    chk("t6_k0_b1_r7c7", lane(b1, 31), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
